// File: rtl/dcache_pkg.sv
// Shared widths, address field helpers and refill FSM states for the data-cache refill path.
// Optional build macro used by the refill files: DCACHE_REFILL_CRITICAL_FIRST_EN.
package dcache_pkg;

    localparam int DOUBLE_WORD_OFFSET_WIDTH = 3;
    localparam int LINE_WIDTH               = 6;
    localparam int BLOCK_OFFSET_WIDTH       = DOUBLE_WORD_OFFSET_WIDTH + 3;
    localparam int TAG_WIDTH                = 32 - BLOCK_OFFSET_WIDTH - LINE_WIDTH;
    localparam int BLOCK_SIZE               = 1 << DOUBLE_WORD_OFFSET_WIDTH;
    localparam int BLOCK_WIDTH              = 64 * BLOCK_SIZE;
    localparam int BEAT_COUNT_WIDTH         = DOUBLE_WORD_OFFSET_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        COLLECT,
        WRITE
    } state_t;

    function automatic logic [TAG_WIDTH-1:0] get_tag(input logic [31:0] address);
        return address[31 -: TAG_WIDTH];
    endfunction

    function automatic logic [LINE_WIDTH-1:0] get_line(input logic [31:0] address);
        return address[BLOCK_OFFSET_WIDTH +: LINE_WIDTH];
    endfunction

    function automatic logic [DOUBLE_WORD_OFFSET_WIDTH-1:0] get_word_offset(input logic [31:0] address);
        return address[3 +: DOUBLE_WORD_OFFSET_WIDTH];
    endfunction

endpackage

// File: rtl/dcache_refill_unit_if.sv
// Bundle of the miss request, memory read channel and storage write port seen by the refill unit.
// Carries critical_valid/critical_data only when DCACHE_REFILL_CRITICAL_FIRST_EN is defined.
interface dcache_refill_unit_if
    import dcache_pkg::*;
();

    logic                   miss_valid;
    logic                   miss_ready;
    logic [31:0]            miss_address;

    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [31:0]            mem_req_address;

    logic                   mem_resp_valid;
    logic                   mem_resp_ready;
    logic [63:0]            mem_resp_data;

    logic                   write_in;
    logic [LINE_WIDTH-1:0]  write_line_index;
    logic [BLOCK_WIDTH-1:0] write_block;
    logic [TAG_WIDTH-1:0]   write_tag;
    logic [BLOCK_SIZE-1:0]  write_mask;
    logic                   refill_done;

`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
    logic                   critical_valid;
    logic [63:0]            critical_data;
`endif

    // master is the refill unit; slave is the cache/memory environment around it
    modport master (
        input  miss_valid, miss_address, mem_req_ready, mem_resp_valid, mem_resp_data,
        output miss_ready, mem_req_valid, mem_req_address, mem_resp_ready,
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
        output critical_valid, critical_data,
`endif
        output write_in, write_line_index, write_block, write_tag, write_mask, refill_done
    );

    modport slave (
        output miss_valid, miss_address, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  miss_ready, mem_req_valid, mem_req_address, mem_resp_ready,
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
        input  critical_valid, critical_data,
`endif
        input  write_in, write_line_index, write_block, write_tag, write_mask, refill_done
    );

endinterface

// File: rtl/dcache_refill_buffer.sv
// Block assembly buffer: BLOCK_SIZE double words, one beat written per cycle at an arbitrary index.
// Contents are never cleared; a full refill overwrites every word.
module dcache_refill_buffer
    import dcache_pkg::*;
(
    input  logic                                clock,
    input  logic                                write_enable,
    input  logic [DOUBLE_WORD_OFFSET_WIDTH-1:0] write_index,
    input  logic [63:0]                         write_data,
    output logic [BLOCK_WIDTH-1:0]              block
);

    logic [63:0] words [BLOCK_SIZE];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            words[write_index] <= write_data;
        end
    end

    for (genvar j = 0; j < BLOCK_SIZE; j++) begin : g_flatten
        assign block[64*j +: 64] = words[j];
    end

endmodule

// File: rtl/dcache_refill_unit.sv
// Miss-side refill engine: one burst read per miss, assembles the block, then one storage write.
// Define DCACHE_REFILL_CRITICAL_FIRST_EN for critical-word-first bursts and the critical_* outputs.
module dcache_refill_unit
    import dcache_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    dcache_refill_unit_if.master bus
);

    state_t                              state;
    state_t                              next_state;
    logic [31:0]                         miss_address_q;
    logic [BEAT_COUNT_WIDTH-1:0]         beat_count;
    logic                                miss_accept;
    logic                                beat_accept;
    logic                                last_beat;
    logic [DOUBLE_WORD_OFFSET_WIDTH-1:0] start_index;
    logic [DOUBLE_WORD_OFFSET_WIDTH-1:0] buffer_index;
    logic                                unused_address_bits;

    assign miss_accept = bus.miss_valid && bus.miss_ready;
    assign beat_accept = bus.mem_resp_valid && bus.mem_resp_ready;
    assign last_beat   = beat_accept && (beat_count == BEAT_COUNT_WIDTH'(BLOCK_SIZE - 1));

`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
    // memory returns beats in wrap order starting at the missing double word
    assign start_index         = get_word_offset(miss_address_q);
    assign bus.mem_req_address = {miss_address_q[31:3], 3'b000};
    assign bus.critical_valid  = beat_accept && (beat_count == '0);
    assign bus.critical_data   = bus.mem_resp_data;
    assign unused_address_bits = ^miss_address_q[2:0];
`else
    assign start_index         = '0;
    assign bus.mem_req_address = {miss_address_q[31:BLOCK_OFFSET_WIDTH], {BLOCK_OFFSET_WIDTH{1'b0}}};
    assign unused_address_bits = ^miss_address_q[BLOCK_OFFSET_WIDTH-1:0];
`endif

    // index arithmetic wraps modulo BLOCK_SIZE by truncation
    assign buffer_index = start_index + beat_count[DOUBLE_WORD_OFFSET_WIDTH-1:0];

    assign bus.write_line_index = get_line(miss_address_q);
    assign bus.write_tag        = get_tag(miss_address_q);
    assign bus.write_mask       = '1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            beat_count <= '0;
        end else begin
            state <= next_state;
            if (state == REQ) begin
                beat_count <= '0;
            end else if (beat_accept) begin
                beat_count <= beat_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (miss_accept) begin
            miss_address_q <= bus.miss_address;
        end
    end

    always_comb begin
        next_state         = state;
        bus.miss_ready     = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_resp_ready = 1'b0;
        bus.write_in       = 1'b0;
        bus.refill_done    = 1'b0;
        case (state)
            IDLE: begin
                bus.miss_ready = 1'b1;
                if (bus.miss_valid) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                bus.mem_resp_ready = 1'b1;
                if (last_beat) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                bus.write_in    = 1'b1;
                bus.refill_done = 1'b1;
                next_state      = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    dcache_refill_buffer u_buffer (
        .clock        (clock),
        .write_enable (beat_accept),
        .write_index  (buffer_index),
        .write_data   (bus.mem_resp_data),
        .block        (bus.write_block)
    );

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Directed bench for dcache_refill_unit; expectations adapt when DCACHE_REFILL_CRITICAL_FIRST_EN is defined.
module tb_dcache_refill_unit;

    logic clock;
    logic reset;
    int   compared;
    int   mismatched;

    dcache_refill_unit_if bus ();

    dcache_refill_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // one full miss: accept, request with optional backpressure, beats with optional gaps, write
    task automatic apply_stimulus(input logic [31:0] address, input logic [63:0] base,
                                  input logic [5:0] exp_line, input logic [19:0] exp_tag,
                                  input int req_delay, input int gap, input bit stray);
        logic [511:0] exp_block;
        logic [31:0]  exp_req;
        int           start;
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
        exp_req = {address[31:3], 3'b000};
        start   = int'(address[5:3]);
`else
        exp_req = {address[31:6], 6'b000000};
        start   = 0;
`endif
        exp_block = '0;
        for (int j = 0; j < 8; j++) begin
            exp_block[64*((start + j) % 8) +: 64] = base + 64'(j);
        end

        bus.miss_valid   = 1'b1;
        bus.miss_address = address;
        check_output("miss_ready_idle", 512'(bus.miss_ready), 512'(1));
        tick();
        bus.miss_valid   = 1'b0;
        bus.miss_address = 32'hDEAD_BEEF;
        check_output("req_valid_after_accept", 512'(bus.mem_req_valid), 512'(1));
        check_output("req_address", 512'(bus.mem_req_address), 512'(exp_req));

        if (stray) begin
            bus.miss_valid     = 1'b1;
            bus.miss_address   = 32'h0F0F_0F00;
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
            #1;
            check_output("miss_ready_busy", 512'(bus.miss_ready), 512'(0));
            check_output("resp_ready_in_req", 512'(bus.mem_resp_ready), 512'(0));
        end

        for (int i = 0; i < req_delay; i++) begin
            tick();
            check_output("req_valid_held", 512'(bus.mem_req_valid), 512'(1));
            check_output("req_address_held", 512'(bus.mem_req_address), 512'(exp_req));
        end

        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.miss_valid     = 1'b0;
        bus.mem_resp_valid = 1'b0;
        check_output("single_request", 512'(bus.mem_req_valid), 512'(0));

        for (int b = 0; b < 8; b++) begin
            for (int g = 0; g < gap; g++) begin
                tick();
                check_output("no_write_during_gap", 512'(bus.write_in), 512'(0));
            end
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = base + 64'(b);
            #1;
            check_output("resp_ready_collect", 512'(bus.mem_resp_ready), 512'(1));
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
            check_output("critical_valid", 512'(bus.critical_valid), 512'(b == 0));
            if (b == 0) begin
                check_output("critical_data", 512'(bus.critical_data), 512'(base));
            end
`endif
            tick();
            bus.mem_resp_valid = 1'b0;
        end

        check_output("write_in_after_last", 512'(bus.write_in), 512'(1));
        check_output("refill_done", 512'(bus.refill_done), 512'(1));
        check_output("write_line_index", 512'(bus.write_line_index), 512'(exp_line));
        check_output("write_tag", 512'(bus.write_tag), 512'(exp_tag));
        check_output("write_mask", 512'(bus.write_mask), 512'(8'hFF));
        check_output("write_block", 512'(bus.write_block), exp_block);
        tick();
        check_output("write_in_one_cycle", 512'(bus.write_in), 512'(0));
        check_output("refill_done_one_cycle", 512'(bus.refill_done), 512'(0));
    endtask

    initial begin
        compared           = 0;
        mismatched         = 0;
        reset              = 1'b1;
        bus.miss_valid     = 1'b0;
        bus.miss_address   = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        tick();
        tick();

        $display("[TB] reset state");
        check_output("reset_miss_ready", 512'(bus.miss_ready), 512'(1));
        check_output("reset_req_valid", 512'(bus.mem_req_valid), 512'(0));
        check_output("reset_resp_ready", 512'(bus.mem_resp_ready), 512'(0));
        check_output("reset_write_in", 512'(bus.write_in), 512'(0));
        check_output("reset_refill_done", 512'(bus.refill_done), 512'(0));
        check_output("reset_write_mask", 512'(bus.write_mask), 512'(8'hFF));
        reset = 1'b0;
        tick();

        $display("[TB] basic refill");
        apply_stimulus(32'h0000_1248, 64'h100, 6'h09, 20'h00001, 0, 0, 1'b0);

        $display("[TB] backpressure and beat gaps");
        apply_stimulus(32'h0000_2F80, 64'h5000, 6'h3E, 20'h00002, 3, 2, 1'b0);

        $display("[TB] busy miss and stray beat in REQ");
        apply_stimulus(32'h8000_0040, 64'hA000_0000_0000_0000, 6'h01, 20'h80000, 2, 0, 1'b1);

        $display("[TB] reset mid-collect");
        bus.miss_valid   = 1'b1;
        bus.miss_address = 32'h0000_1248;
        tick();
        bus.miss_valid    = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 64'h200 + 64'(b);
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("abort_miss_ready", 512'(bus.miss_ready), 512'(1));
        check_output("abort_resp_ready", 512'(bus.mem_resp_ready), 512'(0));
        check_output("abort_req_valid", 512'(bus.mem_req_valid), 512'(0));
        for (int i = 0; i < 3; i++) begin
            check_output("abort_no_write", 512'(bus.write_in), 512'(0));
            tick();
        end
        apply_stimulus(32'h0000_1248, 64'h300, 6'h09, 20'h00001, 0, 0, 1'b0);

        $display("[TB] back-to-back misses");
        apply_stimulus(32'hABCD_EFC0, 64'h1111_0000, 6'h3F, 20'hABCDE, 0, 0, 1'b0);
        apply_stimulus(32'h1234_5008, 64'h2222_0000, 6'h00, 20'h12345, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
